// File: rtl/sd_cache_lock_responder_pkg.sv
// sd_lock_pkg: shared lock FSM state, owner-width helper and reset constants.
package sd_lock_pkg;
    typedef enum logic {UNLOCKED, HELD} lock_state_t;
    localparam logic LOCK_RST = 1'b0;
    localparam logic [3:0] OWNER_RST = '0;
    function automatic int owner_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sd_cache_lock_responder_if.sv
// sd_cache_lock_responder_if: requester-side lock/unlock handshake bundle.
interface sd_cache_lock_responder_if import sd_lock_pkg::*; #(
    parameter int NUM_REQ = 4
);
    localparam int OWNER_W = owner_w(NUM_REQ);
    logic [NUM_REQ-1:0] lock_req;
    logic [NUM_REQ-1:0] unlock_req;
    logic [NUM_REQ-1:0] lock_ack;
    logic [NUM_REQ-1:0] unlock_ack;
    logic [NUM_REQ-1:0] unlock_deny;
    logic               locked;
    logic [OWNER_W-1:0] owner;
    logic               timeout_evt;
    modport master (
        output lock_req, unlock_req,
        input  lock_ack, unlock_ack, unlock_deny, locked, owner, timeout_evt
    );
    modport slave (
        input  lock_req, unlock_req,
        output lock_ack, unlock_ack, unlock_deny, locked, owner, timeout_evt
    );
endinterface

// File: rtl/sd_cache_lock_responder_rr_arbiter.sv
// sd_lock_rr_arbiter: combinational round-robin pick starting at ptr, wrapping to 0.
module sd_lock_rr_arbiter import sd_lock_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int OWNER_W = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OWNER_W-1:0] id
);
    always_comb begin
        gnt = '0;
        id  = '0;
        // descending scan so the candidate closest to ptr is written last
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) begin
                gnt = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
                id  = OWNER_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/sd_cache_lock_responder.sv
// sd_cache_lock_responder: arbitrates SD cache lock ownership across NUM_REQ requesters.
// Optional forced release after TIMEOUT_CYCLES held cycles when SD_LOCK_TIMEOUT_EN is defined.
module sd_cache_lock_responder import sd_lock_pkg::*; #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                       clk,
    input logic                       rst_n,
    sd_cache_lock_responder_if.slave  bus
);
    localparam int OWNER_W = owner_w(NUM_REQ);
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sd_cache_lock_responder: unsupported NUM_REQ/TIMEOUT_CYCLES");
    end
    lock_state_t        state;
    logic [OWNER_W-1:0] ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [OWNER_W-1:0] gnt_id;
    logic [NUM_REQ-1:0] owner_oh;
    assign owner_oh = NUM_REQ'(1) << bus.owner;
    sd_lock_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.lock_req),
        .ptr (ptr),
        .gnt (gnt),
        .id  (gnt_id)
    );
`ifdef SD_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] hold_cnt;
`else
    assign bus.timeout_evt = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= UNLOCKED;
            ptr             <= '0;
            bus.locked      <= LOCK_RST;
            bus.owner       <= OWNER_W'(OWNER_RST);
            bus.lock_ack    <= '0;
            bus.unlock_ack  <= '0;
            bus.unlock_deny <= '0;
`ifdef SD_LOCK_TIMEOUT_EN
            bus.timeout_evt <= 1'b0;
            hold_cnt        <= '0;
`endif
        end else begin
            bus.lock_ack    <= '0;
            bus.unlock_ack  <= '0;
            bus.unlock_deny <= state == UNLOCKED ? bus.unlock_req : bus.unlock_req & ~owner_oh;
`ifdef SD_LOCK_TIMEOUT_EN
            bus.timeout_evt <= 1'b0;
`endif
            if (state == UNLOCKED) begin
                if (|bus.lock_req) begin
                    state        <= HELD;
                    bus.locked   <= 1'b1;
                    bus.owner    <= gnt_id;
                    bus.lock_ack <= gnt;
                    ptr          <= gnt_id == OWNER_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
`ifdef SD_LOCK_TIMEOUT_EN
                    hold_cnt     <= '0;
`endif
                end
            end else if (bus.unlock_req[bus.owner]) begin
                state          <= UNLOCKED;
                bus.locked     <= LOCK_RST;
                bus.unlock_ack <= owner_oh;
            end
`ifdef SD_LOCK_TIMEOUT_EN
            else if (hold_cnt == HOLD_LAST) begin
                state           <= UNLOCKED;
                bus.locked      <= LOCK_RST;
                bus.timeout_evt <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sd_cache_lock_responder.sv
// tb_sd_cache_lock_responder: directed plus random requester traffic against a behavioural lock model.
module tb_sd_cache_lock_responder;
    localparam int N = 4;
    localparam int T = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sd_cache_lock_responder_if #(.NUM_REQ(N)) bus();
    sd_cache_lock_responder #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    bit m_locked;
    int m_owner, m_ptr, m_hold;
    logic [N-1:0] e_ack, e_uack, e_deny;
    logic e_tevt;
    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask
    // Reference: lock ownership rules evaluated on the inputs seen at a clock edge.
    task automatic model_step();
        logic [N-1:0] lr, ur;
        bit found;
        lr = bus.lock_req;
        ur = bus.unlock_req;
        e_ack = '0; e_uack = '0; e_tevt = 1'b0;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_hold = 0; e_deny = '0;
            return;
        end
        e_deny = m_locked ? ur & ~(N'(1) << m_owner) : ur;
        if (!m_locked) begin
            found = 0;
            for (int k = 0; k < N; k++)
                if (!found && lr[(m_ptr + k) % N]) begin
                    found = 1;
                    m_owner = (m_ptr + k) % N;
                end
            if (found) begin
                m_locked = 1;
                e_ack = N'(1) << m_owner;
                m_ptr = (m_owner + 1) % N;
                m_hold = 0;
            end
        end else if (ur[m_owner]) begin
            m_locked = 0;
            e_uack = N'(1) << m_owner;
        end else begin
`ifdef SD_LOCK_TIMEOUT_EN
            if (m_hold == T - 1) begin
                m_locked = 0;
                e_tevt = 1;
            end else m_hold++;
`endif
        end
    endtask
    task automatic compare();
        chk("lock_ack", bus.lock_ack, e_ack);
        chk("unlock_ack", bus.unlock_ack, e_uack);
        chk("unlock_deny", bus.unlock_deny, e_deny);
        chk("locked", bus.locked, m_locked);
        chk("owner", bus.owner, m_owner);
        chk("timeout_evt", bus.timeout_evt, e_tevt);
    endtask
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask
    task automatic do_reset();
        rst_n = 0;
        bus.lock_req = '0;
        bus.unlock_req = '0;
        cycle();
        cycle();
        rst_n = 1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.lock_req = '0;
        bus.unlock_req = '0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        chk("idle_locked", bus.locked, 0);
        chk("idle_owner", bus.owner, 0);
        chk("idle_pulses", {bus.lock_ack, bus.unlock_ack, bus.unlock_deny}, 0);
        bus.lock_req = 4'b0100;
        cycle();
        chk("d_ack2", bus.lock_ack, 4'b0100);
        chk("d_locked2", bus.locked, 1);
        chk("d_owner2", bus.owner, 2);
        bus.lock_req = '0;
        bus.unlock_req = 4'b0001;
        cycle();
        chk("d_deny0", bus.unlock_deny, 4'b0001);
        chk("d_still_locked", bus.locked, 1);
        chk("d_still_owner2", bus.owner, 2);
        bus.unlock_req = 4'b0100;
        cycle();
        chk("d_uack2", bus.unlock_ack, 4'b0100);
        chk("d_unlocked", bus.locked, 0);
        bus.unlock_req = 4'b1000;
        cycle();
        chk("d_deny3_unlocked", bus.unlock_deny, 4'b1000);
        bus.unlock_req = '0;
        do_reset();
        bus.lock_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cycle();
            chk("rr_owner", bus.owner, g % N);
            chk("rr_ack", bus.lock_ack, 4'b0001 << (g % N));
            bus.unlock_req = 4'b0001 << (g % N);
            cycle();
            chk("rr_uack", bus.unlock_ack, 4'b0001 << (g % N));
            chk("rr_gap", bus.locked, 0);
            bus.unlock_req = '0;
        end
        do_reset();
        bus.lock_req = 4'b0010;
        cycle();
        chk("s_owner1", bus.owner, 1);
        bus.lock_req = 4'b0001;
        bus.unlock_req = 4'b0010;
        cycle();
        chk("s_uack1", bus.unlock_ack, 4'b0010);
        chk("s_noack", bus.lock_ack, 0);
        chk("s_gap", bus.locked, 0);
        bus.unlock_req = '0;
        cycle();
        chk("s_ack0", bus.lock_ack, 4'b0001);
        chk("s_owner0", bus.owner, 0);
        bus.lock_req = '0;
        rst_n = 0;
        cycle();
        chk("rst_held_locked", bus.locked, 0);
        chk("rst_held_uack", bus.unlock_ack, 0);
        rst_n = 1;
        cycle();
        bus.lock_req = 4'b1000;
        cycle();
        chk("t_owner3", bus.owner, 3);
        bus.lock_req = '0;
        begin
            int n;
            bit seen;
            n = 0;
            seen = 0;
            for (int c = 1; c <= 100 && !seen; c++) begin
                cycle();
                if (bus.timeout_evt) begin
                    seen = 1;
                    n = c;
                end
            end
`ifdef SD_LOCK_TIMEOUT_EN
            chk("t_cycles", n, T);
            chk("t_released", bus.locked, 0);
`else
            chk("t_no_evt", seen, 0);
            chk("t_still_locked", bus.locked, 1);
`endif
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.lock_req[i] && e_ack[i]) bus.lock_req[i] = 0;
                else if (!bus.lock_req[i] && $urandom_range(7) == 0) bus.lock_req[i] = 1;
                if (bus.unlock_req[i] && (e_uack[i] || e_deny[i])) bus.unlock_req[i] = 0;
                else if (!bus.unlock_req[i])
                    bus.unlock_req[i] = (m_locked && m_owner == i) ? ($urandom_range(5) == 0)
                                                                  : ($urandom_range(31) == 0);
            end
            rst_n = $urandom_range(299) != 0;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
